// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with valid/ready handshakes on the input and result sides.
module bin2bcd_seq #(
  parameter int W = 14,
  parameter int D = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              bin,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [4*D-1:0]            bcd,
  output logic                      ovf,
  output logic [$clog2(D+1)-1:0]    ndig,
  output logic                      busy
);

  localparam int CW = $clog2(W+1);
  localparam int NW = $clog2(D+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   bin_reg, bin_next;
  logic [4*D-1:0] bcd_reg, bcd_next;
  logic           ovf_reg, ovf_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [4*D-1:0] adj;

  // Add-3 on every digit >= 5; the 4-bit result never carries into a neighbour.
  genvar gi;
  generate
    for (gi = 0; gi < D; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                              bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      bin_reg   <= '0;
      bcd_reg   <= '0;
      ovf_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      bin_reg   <= bin_next;
      bcd_reg   <= bcd_next;
      ovf_reg   <= ovf_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    bin_next   = bin_reg;
    bcd_next   = bcd_reg;
    ovf_next   = ovf_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          bin_next   = bin;
          bcd_next   = '0;
          ovf_next   = 1'b0;
          cnt_next   = CW'(W);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        // A bit shifted out of the top digit means the value is >= 10^D.
        bcd_next = {adj[4*D-2:0], bin_reg[W-1]};
        bin_next = bin_reg << 1;
        ovf_next = ovf_reg | adj[4*D-1];
        cnt_next = cnt_reg - CW'(1);
        if (cnt_reg == CW'(1))
          state_next = DONE;
      end
      DONE: begin
        if (out_ready)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ndig = NW'(1);
    for (int i = 0; i < D; i++) begin
      if (bcd_reg[4*i +: 4] != 4'd0)
        ndig = NW'(i + 1);
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == SHIFT) || (state_reg == DONE);
  assign bcd       = bcd_reg;
  assign ovf       = ovf_reg;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and table-driven bench for bin2bcd_seq at W=14/D=4 and W=20/D=6.
module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // W=14, D=4 instance
  logic        in_valid14 = 1'b0, out_ready14 = 1'b0;
  logic [13:0] bin14 = '0;
  logic        in_ready14, out_valid14, ovf14, busy14;
  logic [15:0] bcd14;
  logic [2:0]  ndig14;

  // W=20, D=6 instance
  logic        in_valid20 = 1'b0, out_ready20 = 1'b0;
  logic [19:0] bin20 = '0;
  logic        in_ready20, out_valid20, ovf20, busy20;
  logic [23:0] bcd20;
  logic [2:0]  ndig20;

  bin2bcd_seq #(.W(14), .D(4)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14),
    .bin(bin14), .out_valid(out_valid14), .out_ready(out_ready14),
    .bcd(bcd14), .ovf(ovf14), .ndig(ndig14), .busy(busy14)
  );

  bin2bcd_seq #(.W(20), .D(6)) dut20 (
    .clk(clk), .rst(rst), .in_valid(in_valid20), .in_ready(in_ready20),
    .bin(bin20), .out_valid(out_valid20), .out_ready(out_ready20),
    .bcd(bcd20), .ovf(ovf20), .ndig(ndig20), .busy(busy20)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lat counts the accept cycle plus every cycle until out_valid is seen.
  task automatic conv14(input logic [13:0] v, output logic [15:0] r_bcd,
                        output logic r_ovf, output logic [2:0] r_ndig, output int lat);
    int n = 0;
    while (!in_ready14 && n < 200) begin tick(); n++; end
    chk("in_ready14_wait", {31'd0, in_ready14}, 32'd1);
    bin14 = v;
    in_valid14 = 1'b1;
    tick();
    in_valid14 = 1'b0;
    lat = 1;
    while (!out_valid14 && lat < 200) begin tick(); lat++; end
    r_bcd = bcd14; r_ovf = ovf14; r_ndig = ndig14;
    $display("conv14 bin=%0d bcd=%h ovf=%0b ndig=%0d lat=%0d", v, r_bcd, r_ovf, r_ndig, lat);
    out_ready14 = 1'b1;
    tick();
    out_ready14 = 1'b0;
  endtask

  task automatic conv20(input logic [19:0] v, output logic [23:0] r_bcd,
                        output logic r_ovf, output logic [2:0] r_ndig, output int lat);
    int n = 0;
    while (!in_ready20 && n < 200) begin tick(); n++; end
    chk("in_ready20_wait", {31'd0, in_ready20}, 32'd1);
    bin20 = v;
    in_valid20 = 1'b1;
    tick();
    in_valid20 = 1'b0;
    lat = 1;
    while (!out_valid20 && lat < 200) begin tick(); lat++; end
    r_bcd = bcd20; r_ovf = ovf20; r_ndig = ndig20;
    $display("conv20 bin=%0d bcd=%h ovf=%0b ndig=%0d lat=%0d", v, r_bcd, r_ovf, r_ndig, lat);
    out_ready20 = 1'b1;
    tick();
    out_ready20 = 1'b0;
  endtask

  // Reference model for the six-digit instance: bin mod 10^6, digit by digit.
  function automatic logic [23:0] ref_bcd6(input int v);
    logic [23:0] r;
    int m;
    r = '0;
    m = v % 1000000;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [2:0] ref_ndig6(input logic [23:0] b);
    logic [2:0] n;
    n = 3'd1;
    for (int i = 0; i < 6; i++)
      if (b[4*i +: 4] != 4'd0) n = 3'(i + 1);
    return n;
  endfunction

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
    logic [2:0]  ndig;
  } vec14_t;

  vec14_t vecs[8];

  initial begin
    logic [15:0] r_bcd;
    logic        r_ovf;
    logic [2:0]  r_ndig;
    logic [23:0] r_bcd20, e_bcd20;
    int          lat;
    int          n;
    int          v;

    vecs[0] = '{14'd9999,  16'h9999, 1'b0, 3'd4};
    vecs[1] = '{14'd0,     16'h0000, 1'b0, 3'd1};
    vecs[2] = '{14'd10,    16'h0010, 1'b0, 3'd2};
    vecs[3] = '{14'd16383, 16'h6383, 1'b1, 3'd4};
    vecs[4] = '{14'd10000, 16'h0000, 1'b1, 3'd1};
    vecs[5] = '{14'd1,     16'h0001, 1'b0, 3'd1};
    vecs[6] = '{14'd305,   16'h0305, 1'b0, 3'd3};
    vecs[7] = '{14'd1000,  16'h1000, 1'b0, 3'd4};

    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_in_ready",  {31'd0, in_ready14},  32'd1);
    chk("rst_out_valid", {31'd0, out_valid14}, 32'd0);
    chk("rst_busy",      {31'd0, busy14},      32'd0);
    chk("rst_bcd",       {16'd0, bcd14},       32'h0);
    chk("rst_ovf",       {31'd0, ovf14},       32'd0);
    chk("rst_ndig",      {29'd0, ndig14},      32'd1);

    // Table-driven conversions
    for (int i = 0; i < 8; i++) begin
      conv14(vecs[i].bin, r_bcd, r_ovf, r_ndig, lat);
      chk($sformatf("tbl%0d_bcd", i),  {16'd0, r_bcd},  {16'd0, vecs[i].bcd});
      chk($sformatf("tbl%0d_ovf", i),  {31'd0, r_ovf},  {31'd0, vecs[i].ovf});
      chk($sformatf("tbl%0d_ndig", i), {29'd0, r_ndig}, {29'd0, vecs[i].ndig});
      chk($sformatf("tbl%0d_lat", i),  lat, 32'd15);
      chk($sformatf("tbl%0d_in_ready_after", i), {31'd0, in_ready14}, 32'd1);
    end

    // Backpressure: 1234 held in DONE for 20 cycles while 42 is offered.
    bin14 = 14'd1234;
    in_valid14 = 1'b1;
    tick();
    in_valid14 = 1'b0;
    chk("bp_busy_shift", {31'd0, busy14}, 32'd1);
    n = 0;
    while (!out_valid14 && n < 200) begin tick(); n++; end
    chk("bp_out_valid", {31'd0, out_valid14}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      bin14 = 14'd42;
      in_valid14 = i[0];
      tick();
      chk("bp_hold_bcd",      {16'd0, bcd14},       32'h1234);
      chk("bp_hold_in_ready", {31'd0, in_ready14},  32'd0);
      chk("bp_hold_valid",    {31'd0, out_valid14}, 32'd1);
    end
    $display("backpressure bin=1234 bcd=%h held 20 cycles", bcd14);
    in_valid14 = 1'b0;
    out_ready14 = 1'b1;
    tick();
    out_ready14 = 1'b0;
    chk("bp_release_in_ready",  {31'd0, in_ready14},  32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid14}, 32'd0);
    conv14(14'd4321, r_bcd, r_ovf, r_ndig, lat);
    chk("bp_next_bcd", {16'd0, r_bcd}, 32'h4321);
    chk("bp_next_ovf", {31'd0, r_ovf}, 32'd0);

    // Reset in the middle of a conversion.
    bin14 = 14'd5555;
    in_valid14 = 1'b1;
    tick();
    in_valid14 = 1'b0;
    repeat (5) tick();
    chk("abort_busy_before", {31'd0, busy14}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    $display("abort bin=5555 in_ready=%0b out_valid=%0b bcd=%h", in_ready14, out_valid14, bcd14);
    chk("abort_in_ready",  {31'd0, in_ready14},  32'd1);
    chk("abort_out_valid", {31'd0, out_valid14}, 32'd0);
    chk("abort_bcd",       {16'd0, bcd14},       32'h0);
    chk("abort_busy",      {31'd0, busy14},      32'd0);
    conv14(14'd777, r_bcd, r_ovf, r_ndig, lat);
    chk("abort_next_bcd",  {16'd0, r_bcd},  32'h0777);
    chk("abort_next_ndig", {29'd0, r_ndig}, 32'd3);

    // Six-digit instance: boundary values
    conv20(20'd999999, r_bcd20, r_ovf, r_ndig, lat);
    chk("w20_max_bcd",  {8'd0, r_bcd20}, 32'h999999);
    chk("w20_max_ovf",  {31'd0, r_ovf},  32'd0);
    chk("w20_max_ndig", {29'd0, r_ndig}, 32'd6);
    chk("w20_max_lat",  lat, 32'd21);
    conv20(20'd1048575, r_bcd20, r_ovf, r_ndig, lat);
    chk("w20_full_bcd",  {8'd0, r_bcd20}, 32'h048575);
    chk("w20_full_ovf",  {31'd0, r_ovf},  32'd1);
    chk("w20_full_ndig", {29'd0, r_ndig}, 32'd5);

    // Randomised sweep against bin mod 10^6
    for (int i = 0; i < 12; i++) begin
      v = int'($urandom_range(0, 1048575));
      e_bcd20 = ref_bcd6(v);
      conv20(20'(v), r_bcd20, r_ovf, r_ndig, lat);
      chk($sformatf("rnd%0d_bcd", i),  {8'd0, r_bcd20}, {8'd0, e_bcd20});
      chk($sformatf("rnd%0d_ovf", i),  {31'd0, r_ovf},  {31'd0, (v >= 1000000)});
      chk($sformatf("rnd%0d_ndig", i), {29'd0, r_ndig}, {29'd0, ref_ndig6(e_bcd20)});
      chk($sformatf("rnd%0d_lat", i),  lat, 32'd21);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces the fixed 14-bit combinational add-3 tree wherever a wide or configurable conversion is needed and area matters more than latency. It sits between a binary counter or measurement source and the 7-segment display driver, with valid/ready handshakes on both sides.

## Interface
- `W`, default 14: binary input width; must be ≥ 1.
- `D`, default 4: number of BCD output digits; must be ≥ 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: `bin` holds a value to convert.
- `in_ready` output 1: block can accept a value; high only in IDLE.
- `bin` input W: unsigned binary value, sampled on accept.
- `out_valid` output 1: `bcd`, `ovf` and `ndig` hold a result.
- `out_ready` input 1: downstream accepts the result.
- `bcd` output 4*D: packed BCD; digit i is `bcd[4i+3:4i]`, digit 0 is the units.
- `ovf` output 1: input was ≥ 10^D; `bcd` then holds `bin mod 10^D`.
- `ndig` output clog2(D+1): number of significant digits, range 1..D; a value of 0 reports 1.
- `busy` output 1: high in SHIFT or DONE.

## Operation
- FSM states are IDLE, SHIFT and DONE.
- **IDLE:** `in_ready`=1. On `in_valid`, the block:
  - loads `bin` into the shift register;
  - clears the BCD register and `ovf`;
  - sets the iteration counter to W;
  - moves to SHIFT.
- **SHIFT:** one iteration per cycle.
  - Every digit ≥ 5 gets +3 (4-bit result, no carry into the neighbour).
  - The {BCD, binary} register then shifts left by 1. The binary MSB enters BCD bit 0.
  - The bit leaving BCD bit 4D-1 is ORed into `ovf` (sticky).
  - The counter decrements. When the counter reaches 0, the FSM moves to DONE; this happens after exactly W iterations.
- **DONE:** `out_valid`=1 and all outputs hold steady. On `out_ready`, the FSM moves to IDLE.
- `ndig` is combinational from the BCD register: the index of the highest non-zero digit plus 1, or 1 if all digits are zero.
- `in_valid` outside IDLE is ignored. The value is not captured, and the source must hold it until `in_ready` is high.
- The add-3 is applied to all D digits every iteration, including leading zeros, which are unaffected.
- The counter width is clog2(W+1).

## Timing
- **Reset values:**
  - state is IDLE;
  - `in_ready`=1, `out_valid`=0, `busy`=0;
  - `bcd`=0, `ovf`=0, `ndig`=1;
  - counter=0 and the shift register is 0.
- **Reset mid-operation:** `rst` in SHIFT or DONE aborts the conversion on that edge. No `out_valid` is produced and the result is discarded.
- **Latency:** if the accept edge is T, `out_valid` rises after edge T+W, i.e. W+1 cycles after the accept cycle.
- **Throughput:** back-to-back conversions take at least W+2 cycles (accept, W shifts, one DONE cycle with `out_ready`=1). `in_ready` rises the cycle after the DONE handshake.
- **Backpressure:** with `out_ready`=0, DONE holds indefinitely and all outputs stay bit-stable.
- **Simultaneous `rst` and handshake:** reset wins.
- `out_valid`, `in_ready` and `busy` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready` to any output.
- **W=1:** one SHIFT cycle; `out_valid` rises 2 cycles after accept.

## Test plan
- W=14, D=4: `bin`=9999 → `bcd`=0x9999, `ovf`=0, `ndig`=4. `out_valid` rises exactly 15 cycles after the accept cycle.
- `bin`=0 → `bcd`=0x0000, `ndig`=1, `ovf`=0. `bin`=10 → `bcd`=0x0010, `ndig`=2.
- `bin`=16383 → `ovf`=1, `bcd`=0x6383. `bin`=10000 → `ovf`=1, `bcd`=0x0000.
- Apply 1234 with `out_ready`=0 for 20 cycles → `bcd`=0x1234 is held stable and `in_ready` stays 0. Toggle `in_valid` with 42 during this time → 42 is ignored. The next accepted value converts correctly.
- Assert `rst` 5 cycles into converting 5555 → the next cycle shows `in_ready`=1, `out_valid`=0, `bcd`=0. A subsequent 0777 converts to 0x0777.
- Parameters W=20, D=6: 999999 → `bcd`=0x999999, latency 21 cycles. 1048575 → `ovf`=1, `bcd`=0x048575. Randomised sweep against a `bin mod 10^D` reference model.
